// File: rtl/data_ram_responder_if.sv
// Core-side data-memory port of the target RAM responder.
// The core drives address/write strobe/data; the RAM answers with read data and status.
interface data_ram_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] data_rom_addr;
    logic              data_write_en;
    logic [DATA_W-1:0] data_rom_write_data;
    logic [DATA_W-1:0] data_rom_read;
    logic              busy;
    logic [15:0]       wr_count;

    modport master (
        output data_rom_addr,
        output data_write_en,
        output data_rom_write_data,
        input  data_rom_read,
        input  busy,
        input  wr_count
    );

    modport slave (
        input  data_rom_addr,
        input  data_write_en,
        input  data_rom_write_data,
        output data_rom_read,
        output busy,
        output wr_count
    );
endinterface

// File: rtl/data_ram_responder.sv
// Target-side data RAM: async read, single write port shared by the
// post-reset zeroing sweep and the core, plus a saturating write counter.
module data_ram_responder #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 512,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_ram_responder_if.slave  bus
);
    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              busy_q;
    logic [15:0]       wr_count_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              core_wr;

    // rst_n is active-high here; no array write happens in a reset cycle
    assign core_wr = !rst_n && (state == READY) && bus.data_write_en;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.data_rom_addr;
        mem_wd = bus.data_rom_write_data;
        if (!rst_n) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end else if (bus.data_write_en) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= CLEAR_ON_RESET ? CLEAR : READY;
            busy_q     <= CLEAR_ON_RESET;
            clr_ptr    <= '0;
            wr_count_q <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (core_wr && wr_count_q != 16'hFFFF) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end
                end
                default: begin
                    state  <= READY;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.wr_count      = wr_count_q;
    assign bus.data_rom_read = (state == CLEAR) ? '0 : mem[bus.data_rom_addr];
endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: sweep, read/write, same-cycle
// read-during-write, discarded sweep writes, mid-sweep reset, saturation, no-clear variant.
module tb_data_ram_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;

    always #5 clk = ~clk;

    data_ram_responder_if #(.ADDR_W(9), .DATA_W(16)) bus ();
    data_ram_responder_if #(.ADDR_W(9), .DATA_W(16)) bus2 ();

    data_ram_responder #(
        .ADDR_W(9), .DATA_W(16), .DEPTH(512), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    data_ram_responder #(
        .ADDR_W(9), .DATA_W(16), .DEPTH(512), .CLEAR_ON_RESET(1'b0)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst2),
        .bus   (bus2)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] model [512];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) model[i] = 16'h0000;
    endtask

    // push the model's word, let the async read settle, pop and compare
    task automatic rd(input string tag, input logic [8:0] a);
        exp_q.push_back(model[a]);
        bus.data_rom_addr = a;
        #1;
        check(tag, {16'h0, bus.data_rom_read}, {16'h0, exp_q.pop_front()});
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        bus.data_rom_addr       = a;
        bus.data_rom_write_data = d;
        bus.data_write_en       = 1'b1;
        tick();
        bus.data_write_en = 1'b0;
        model[a] = d;
    endtask

    // Reset for one edge, then count busy cycles; optional core write at
    // sweep cycle wr_at and a second reset at sweep cycle rs_at.
    task automatic sweep(input int wr_at, input int rs_at,
                         output int cnt, output bit bad);
        int rs;
        rs = rs_at;
        bad = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.data_rom_addr = 9'h1F0;
        cnt = 0;
        while (bus.busy && cnt < 1000) begin
            if (bus.data_rom_read !== 16'h0000) bad = 1'b1;
            cnt++;
            if (cnt == wr_at) begin
                bus.data_write_en       = 1'b1;
                bus.data_rom_addr       = 9'h010;
                bus.data_rom_write_data = 16'h5555;
            end
            if (cnt == rs) rst = 1'b1;
            tick();
            bus.data_write_en = 1'b0;
            bus.data_rom_addr = 9'h1F0;
            if (rst) begin
                rst = 1'b0;
                cnt = 0;
                rs = -1;
            end
        end
        model_clear();
    endtask

    initial begin
        int  cnt;
        bit  bad;
        int  i;

        bus.data_rom_addr        = '0;
        bus.data_write_en        = 1'b0;
        bus.data_rom_write_data  = '0;
        bus2.data_rom_addr       = '0;
        bus2.data_write_en       = 1'b0;
        bus2.data_rom_write_data = '0;
        model_clear();
        tick();

        // reset state and first sweep
        rst = 1'b1;
        tick();
        check("rst_busy", {31'h0, bus.busy}, 32'h1);
        check("rst_wrcnt", {16'h0, bus.wr_count}, 32'h0);
        rst = 1'b0;
        cnt = 0;
        bad = 1'b0;
        while (bus.busy && cnt < 1000) begin
            if (bus.data_rom_read !== 16'h0000) bad = 1'b1;
            cnt++;
            tick();
        end
        model_clear();
        check("sweep_len", cnt, 512);
        check("sweep_rd0", {31'h0, bad}, 32'h0);
        rd("rd_000", 9'h000);
        rd("rd_0ff", 9'h0FF);
        rd("rd_1ff", 9'h1FF);

        // basic write/read
        wr(9'h005, 16'hBEEF);
        rd("rd_005", 9'h005);
        rd("rd_006", 9'h006);
        check("wrcnt_1", {16'h0, bus.wr_count}, 32'h1);

        // same-cycle read/write at the top address
        wr(9'h1FF, 16'h1234);
        exp_q.push_back(model[9'h1FF]);
        bus.data_rom_addr       = 9'h1FF;
        bus.data_rom_write_data = 16'hABCD;
        bus.data_write_en       = 1'b1;
        #1;
        check("rw_old", {16'h0, bus.data_rom_read}, {16'h0, exp_q.pop_front()});
        tick();
        bus.data_write_en = 1'b0;
        model[9'h1FF] = 16'hABCD;
        rd("rw_new", 9'h1FF);
        check("wrcnt_3", {16'h0, bus.wr_count}, 32'h3);

        // core write during sweep cycle 100 is discarded
        wr(9'h1F0, 16'h7777);
        sweep(100, -1, cnt, bad);
        check("sw2_len", cnt, 512);
        check("sw2_rd0", {31'h0, bad}, 32'h0);
        rd("sw2_010", 9'h010);
        check("sw2_wrcnt", {16'h0, bus.wr_count}, 32'h0);

        // reset at sweep cycle 300 restarts the full sweep
        wr(9'h1F0, 16'h7777);
        rd("pre_1f0", 9'h1F0);
        sweep(-1, 300, cnt, bad);
        check("sw3_len", cnt, 512);
        check("sw3_rd0", {31'h0, bad}, 32'h0);
        rd("sw3_1f0", 9'h1F0);
        check("sw3_wrcnt", {16'h0, bus.wr_count}, 32'h0);

        // saturating write counter
        bus.data_rom_addr = 9'h020;
        bus.data_write_en = 1'b1;
        for (i = 0; i < 65534; i++) begin
            bus.data_rom_write_data = 16'(i);
            tick();
        end
        bus.data_write_en = 1'b0;
        check("wrcnt_fffe", {16'h0, bus.wr_count}, 32'hFFFE);
        bus.data_write_en = 1'b1;
        for (i = 65534; i < 65540; i++) begin
            bus.data_rom_write_data = 16'(i);
            tick();
        end
        bus.data_write_en = 1'b0;
        model[9'h020] = 16'(65539);
        check("wrcnt_sat", {16'h0, bus.wr_count}, 32'hFFFF);
        rd("sat_020", 9'h020);

        // no-clear variant: ready immediately after reset
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("nc_busy", {31'h0, bus2.busy}, 32'h0);
        check("nc_wrcnt", {16'h0, bus2.wr_count}, 32'h0);
        bus2.data_rom_addr       = 9'h042;
        bus2.data_rom_write_data = 16'h3C3C;
        bus2.data_write_en       = 1'b1;
        tick();
        bus2.data_write_en = 1'b0;
        exp_q.push_back(16'h3C3C);
        #1;
        check("nc_rd", {16'h0, bus2.data_rom_read}, {16'h0, exp_q.pop_front()});
        check("nc_wrcnt1", {16'h0, bus2.wr_count}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
